// File: rtl/qed_constraint_pkg.sv
`default_nettype none
// ============================================================================
// Package     : qed_constraint_pkg
// Description : Shared encodings for the SQED instruction-stream constraint.
//               Holds the opcode/funct localparams, the instruction-class and
//               FSM-state enums, and small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package qed_constraint_pkg;

  // Major opcodes
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_NOP   = 7'h7F;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_WORD    = 3'b010;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_R    = 3'd3,
    CLS_SW   = 3'd4,
    CLS_NOP  = 3'd5
  } inst_class_t;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

  // Register index lies inside the original half of the partition.
  function automatic logic reg_ok(input logic [4:0] r, input int unsigned lim);
    return (32'(r) < lim);
  endfunction

  // Offset only uses the low 'bits' bits (upper immediate bits all zero).
  function automatic logic mem_imm_ok(input logic [11:0] imm, input int unsigned bits);
    return ((32'(imm) >> bits) == 32'd0);
  endfunction

endpackage : qed_constraint_pkg
`default_nettype wire

// File: rtl/qed_inst_classify.sv
`default_nettype none
// ============================================================================
// Module      : qed_inst_classify
// Description : Purely combinational decoder. Classifies a fetched word and
//               reports whether it is statically legal for the original
//               SQED stream, together with its register fields and usage.
// Ports       : instruction  in  32  fetched word
//               inst_class   out 3   NONE/I/LW/R/SW/NOP
//               static_ok    out 1   legal ignoring history
//               rs1/rs2/rd   out 5   raw register fields
//               uses_rs1     out 1   word reads rs1
//               uses_rs2     out 1   word reads rs2 (R and SW)
//               is_mem       out 1   LW or SW
// Revision    : 1.0 - initial release
// ============================================================================
module qed_inst_classify
  import qed_constraint_pkg::*;
#(
  parameter int unsigned ORIG_REGS     = 16,
  parameter bit          ENABLE_MULDIV = 1'b1,
  parameter int unsigned MEM_ADDR_BITS = 10
) (
  input  logic [31:0] instruction,
  output inst_class_t inst_class,
  output logic        static_ok,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        is_mem
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        op_ok;
  logic        regs_ok;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm_i  = instruction[31:20];
  assign imm_s  = {instruction[31:25], instruction[11:7]};

  assign static_ok = op_ok && regs_ok;

  always_comb begin
    inst_class = CLS_NONE;
    op_ok      = 1'b0;
    regs_ok    = 1'b0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    is_mem     = 1'b0;
    case (opcode)
      OP_IMM: begin
        inst_class = CLS_I;
        uses_rs1   = 1'b1;
        regs_ok    = reg_ok(rs1, ORIG_REGS) && reg_ok(rd, ORIG_REGS);
        case (funct3)
          F3_SLL:     op_ok = (funct7 == F7_BASE);
          F3_SRL_SRA: op_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default:    op_ok = 1'b1;
        endcase
      end
      OP_REG: begin
        inst_class = CLS_R;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        regs_ok    = reg_ok(rs1, ORIG_REGS) && reg_ok(rs2, ORIG_REGS) &&
                     reg_ok(rd, ORIG_REGS);
        case (funct7)
          F7_BASE:   op_ok = 1'b1;
          F7_ALT:    op_ok = (funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA);
          // funct3 000..011 are MUL/MULH/MULHSU/MULHU; divides stay illegal
          F7_MULDIV: op_ok = ENABLE_MULDIV && !funct3[2];
          default:   op_ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        inst_class = CLS_LW;
        uses_rs1   = 1'b1;
        is_mem     = 1'b1;
        regs_ok    = reg_ok(rd, ORIG_REGS);
        op_ok      = (funct3 == F3_WORD) && (rs1 == 5'd0) &&
                     mem_imm_ok(imm_i, MEM_ADDR_BITS);
      end
      OP_STORE: begin
        inst_class = CLS_SW;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        is_mem     = 1'b1;
        regs_ok    = reg_ok(rs2, ORIG_REGS);
        op_ok      = (funct3 == F3_WORD) && (rs1 == 5'd0) &&
                     mem_imm_ok(imm_s, MEM_ADDR_BITS);
      end
      OP_NOP: begin
        // Every other field is don't-care for the NOP encoding
        inst_class = CLS_NOP;
        op_ok      = 1'b1;
        regs_ok    = 1'b1;
      end
      default: begin
        inst_class = CLS_NONE;
      end
    endcase
  end

endmodule : qed_inst_classify
`default_nettype wire

// File: rtl/qed_inst_constraint_seq.sv
`default_nettype none
// ============================================================================
// Module      : qed_inst_constraint_seq
// Description : Sequential instruction-stream constraint for SQED formal runs.
//               Combines the static decoder with a load-use shadow FSM and a
//               saturating memory-op budget. 'allowed' is combinational; under
//               FORMAL an assumption restricts the fetch stream to allowed
//               words. A sticky violation flag supports simulation.
// Ports       : clk          in  1   clock, rising edge
//               rst          in  1   asynchronous reset, active-high
//               instruction  in  32  fetched word
//               inst_valid   in  1   word accepted by core this cycle
//               restart      in  1   sync clear of shadow, budget, violation
//               allowed      out 1   word legal given current state
//               inst_class   out 3   0 NONE,1 I,2 LW,3 R,4 SW,5 NOP
//               mem_ops      out CW  accepted LW+SW count, saturating
//               shadow       out 1   load-use shadow active
//               violation    out 1   sticky: set on inst_valid && !allowed
// Revision    : 1.0 - initial release
// ============================================================================
module qed_inst_constraint_seq
  import qed_constraint_pkg::*;
#(
  parameter int unsigned ORIG_REGS     = 16,
  parameter bit          ENABLE_MULDIV = 1'b1,
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned LOAD_USE_GAP  = 2,
  parameter int unsigned MAX_MEM_OPS   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [31:0]                        instruction,
  input  logic                               inst_valid,
  input  logic                               restart,
  output logic                               allowed,
  output logic [2:0]                         inst_class,
  output logic [$clog2(MAX_MEM_OPS+1)-1:0]   mem_ops,
  output logic                               shadow,
  output logic                               violation
);

  localparam int unsigned CW     = $clog2(MAX_MEM_OPS + 1);
  localparam int unsigned GW     = (LOAD_USE_GAP < 1) ? 1 : $clog2(LOAD_USE_GAP + 1);
  localparam bit          LU_ON  = (LOAD_USE_GAP > 0);
  localparam logic [CW-1:0] MEM_MAX = CW'(MAX_MEM_OPS);
  localparam logic [GW-1:0] GAP_RLD = GW'(LOAD_USE_GAP);

  // Decoder outputs
  inst_class_t cls;
  logic        static_ok;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        is_mem;

  // State and next-state
  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [GW-1:0]   gap_cnt_nxt;
  logic [4:0]      ld_rd;
  logic [4:0]      ld_rd_nxt;
  logic [CW-1:0]   mem_ops_nxt;
  logic            violation_nxt;

  logic shadow_hit;
  logic budget_hit;
  logic accept;
  logic is_load;

  qed_inst_classify #(
    .ORIG_REGS     (ORIG_REGS),
    .ENABLE_MULDIV (ENABLE_MULDIV),
    .MEM_ADDR_BITS (MEM_ADDR_BITS)
  ) u_classify (
    .instruction (instruction),
    .inst_class  (cls),
    .static_ok   (static_ok),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .is_mem      (is_mem)
  );

  assign inst_class = cls;
  assign shadow     = (state == SHADOW);
  assign is_load    = (cls == CLS_LW);

  // ld_rd==0 never creates a hazard: x0 reads are constant.
  assign shadow_hit = (state == SHADOW) && (ld_rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == ld_rd)) ||
                       (uses_rs2 && (rs2 == ld_rd)));
  assign budget_hit = is_mem && (mem_ops == MEM_MAX);

  assign allowed = static_ok && !shadow_hit && !budget_hit;
  assign accept  = inst_valid && allowed;

  always_comb begin
    state_nxt     = state;
    gap_cnt_nxt   = gap_cnt;
    ld_rd_nxt     = ld_rd;
    mem_ops_nxt   = mem_ops;
    violation_nxt = violation;
    if (restart) begin
      // restart outranks a same-cycle accepted word; that word is dropped
      state_nxt     = RUN;
      gap_cnt_nxt   = '0;
      ld_rd_nxt     = 5'd0;
      mem_ops_nxt   = '0;
      violation_nxt = 1'b0;
    end else begin
      if (inst_valid && !allowed) begin
        violation_nxt = 1'b1;
      end
      if (accept) begin
        if (is_mem && (mem_ops != MEM_MAX)) begin
          mem_ops_nxt = mem_ops + CW'(1);
        end
        if (LU_ON && is_load && (rd != 5'd0)) begin
          // Entering or reloading the shadow behaves identically
          state_nxt   = SHADOW;
          ld_rd_nxt   = rd;
          gap_cnt_nxt = GAP_RLD;
        end else if (state == SHADOW) begin
          gap_cnt_nxt = gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) begin
            state_nxt = RUN;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      gap_cnt   <= '0;
      ld_rd     <= 5'd0;
      mem_ops   <= '0;
      violation <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      ld_rd     <= ld_rd_nxt;
      mem_ops   <= mem_ops_nxt;
      violation <= violation_nxt;
    end
  end

`ifdef FORMAL
  always_comb begin
    if (!rst) begin
      assume (!inst_valid || allowed);
    end
  end
`endif

endmodule : qed_inst_constraint_seq
`default_nettype wire

// File: tb/tb_qed_inst_constraint_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_qed_inst_constraint_seq
// Description : Directed self-checking bench for qed_inst_constraint_seq
//               with default parameters (ORIG_REGS=16, GAP=2, MAX_MEM_OPS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qed_inst_constraint_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        restart;
  logic        allowed;
  logic [2:0]  inst_class;
  logic [3:0]  mem_ops;
  logic        shadow;
  logic        violation;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  qed_inst_constraint_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .restart     (restart),
    .allowed     (allowed),
    .inst_class  (inst_class),
    .mem_ops     (mem_ops),
    .shadow      (shadow),
    .violation   (violation)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply a word just after the falling edge, then let combinational settle.
  task automatic drive(input logic [31:0] i, input logic v, input logic rs);
    @(negedge clk);
    instruction = i;
    inst_valid  = v;
    restart     = rs;
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {imm, r1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2);
    return {imm[11:5], r2, 5'd0, 3'b010, imm[4:0], 7'h23};
  endfunction

  logic [31:0] addi3, add20, lw5, lw7, add651, add615, addi65, sw1, sw5;
  logic [31:0] nop, nopx, mul, div, sub, slli_bad, srai, lw_rs1, lw_big, lw_max, lui;

  initial begin
    addi3    = enc_i(12'd5, 5'd1, 3'b000, 5'd3, 7'h13);
    add20    = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd20);
    lw5      = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'h03);
    lw7      = enc_i(12'd0, 5'd0, 3'b010, 5'd7, 7'h03);
    add651   = enc_r(7'h00, 5'd1, 5'd5, 3'b000, 5'd6);
    add615   = enc_r(7'h00, 5'd5, 5'd1, 3'b000, 5'd6);
    addi65   = enc_i(12'd1, 5'd5, 3'b000, 5'd6, 7'h13);
    sw1      = enc_s(12'd0, 5'd1);
    sw5      = enc_s(12'd0, 5'd5);
    nop      = 32'h0000007F;
    nopx     = 32'hFFFFFFFF;
    mul      = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3);
    div      = enc_r(7'h01, 5'd2, 5'd1, 3'b100, 5'd3);
    sub      = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
    slli_bad = enc_i({7'h20, 5'd3}, 5'd1, 3'b001, 5'd3, 7'h13);
    srai     = enc_i({7'h20, 5'd3}, 5'd1, 3'b101, 5'd3, 7'h13);
    lw_rs1   = enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'h03);
    lw_big   = enc_i(12'h400, 5'd0, 3'b010, 5'd5, 7'h03);
    lw_max   = enc_i(12'h3FC, 5'd0, 3'b010, 5'd5, 7'h03);
    lui      = 32'h000000B7;

    rst = 1'b1; instruction = nop; inst_valid = 1'b0; restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_shadow", 32'(shadow), 0);
    check("rst_mem_ops", 32'(mem_ops), 0);
    check("rst_violation", 32'(violation), 0);
    @(negedge clk) rst = 1'b0;

    // Static legality, evaluated with inst_valid=0 so no state moves
    drive(mul, 1'b0, 1'b0);      check("mul_ok", 32'(allowed), 1);
    drive(div, 1'b0, 1'b0);      check("div_rej", 32'(allowed), 0);
    drive(sub, 1'b0, 1'b0);      check("sub_ok", 32'(allowed), 1);
    drive(slli_bad, 1'b0, 1'b0); check("slli_f7_rej", 32'(allowed), 0);
    drive(srai, 1'b0, 1'b0);     check("srai_ok", 32'(allowed), 1);
    drive(lw_rs1, 1'b0, 1'b0);   check("lw_rs1_rej", 32'(allowed), 0);
    drive(lw_big, 1'b0, 1'b0);   check("lw_imm_rej", 32'(allowed), 0);
    drive(lw_max, 1'b0, 1'b0);   check("lw_imm_ok", 32'(allowed), 1);
    drive(nopx, 1'b0, 1'b0);     check("nopx_ok", 32'(allowed), 1);
                                 check("nopx_cls", 32'(inst_class), 5);
    drive(lui, 1'b0, 1'b0);      check("lui_rej", 32'(allowed), 0);
                                 check("lui_cls", 32'(inst_class), 0);
    drive(sw1, 1'b0, 1'b0);      check("sw_cls", 32'(inst_class), 4);

    // 1: ADDI accepted
    drive(addi3, 1'b1, 1'b0);
    check("t1_allowed", 32'(allowed), 1);
    check("t1_cls", 32'(inst_class), 1);
    drive(nop, 1'b0, 1'b0);
    check("t1_mem_ops", 32'(mem_ops), 0);
    check("t1_violation", 32'(violation), 0);

    // 2: rd out of partition -> sticky violation until restart
    drive(add20, 1'b1, 1'b0);
    check("t2_allowed", 32'(allowed), 0);
    check("t2_cls", 32'(inst_class), 3);
    drive(addi3, 1'b0, 1'b0);
    check("t2_viol_set", 32'(violation), 1);
    drive(addi3, 1'b1, 1'b0);
    check("t2_viol_sticky", 32'(violation), 1);
    drive(nop, 1'b0, 1'b1);
    drive(nop, 1'b0, 1'b0);
    check("t2_viol_clr", 32'(violation), 0);

    // 3: load-use shadow of length 2
    drive(lw5, 1'b1, 1'b0);
    check("t3_lw_allowed", 32'(allowed), 1);
    check("t3_lw_cls", 32'(inst_class), 2);
    drive(add651, 1'b1, 1'b0);
    check("t3_rs1_hit", 32'(allowed), 0);
    check("t3_shadow", 32'(shadow), 1);
    check("t3_mem_ops", 32'(mem_ops), 1);
    drive(add615, 1'b1, 1'b0);
    check("t3_rs2_hit", 32'(allowed), 0);
    drive(addi65, 1'b1, 1'b0);
    check("t3_i_rs1_hit", 32'(allowed), 0);
    drive(nop, 1'b1, 1'b0);
    check("t3_nop1_ok", 32'(allowed), 1);
    check("t3_shadow_held", 32'(shadow), 1);
    drive(nop, 1'b1, 1'b0);
    check("t3_shadow_gap1", 32'(shadow), 1);
    drive(add651, 1'b1, 1'b0);
    check("t3_after_ok", 32'(allowed), 1);
    check("t3_shadow_off", 32'(shadow), 0);
    drive(nop, 1'b0, 1'b1);
    drive(nop, 1'b0, 1'b0);
    check("t3_rst_mem", 32'(mem_ops), 0);
    check("t3_rst_viol", 32'(violation), 0);

    // 4: stalls do not consume the shadow
    drive(lw5, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(add651, 1'b0, 1'b0);
      check("t4_stall_shadow", 32'(shadow), 1);
      check("t4_stall_rej", 32'(allowed), 0);
    end
    drive(nop, 1'b1, 1'b0);
    check("t4_pre1", 32'(shadow), 1);
    drive(nop, 1'b1, 1'b0);
    check("t4_pre2", 32'(shadow), 1);
    drive(nop, 1'b0, 1'b0);
    check("t4_done", 32'(shadow), 0);
    check("t4_mem_ops", 32'(mem_ops), 1);

    // restart beats a same-cycle accepted LW
    drive(lw7, 1'b1, 1'b1);
    check("rs_lw_allowed", 32'(allowed), 1);
    drive(nop, 1'b0, 1'b0);
    check("rs_shadow", 32'(shadow), 0);
    check("rs_mem_ops", 32'(mem_ops), 0);

    // 5: memory-op budget
    for (int k = 0; k < 8; k++) begin
      drive(sw1, 1'b1, 1'b0);
      check("t5_sw_ok", 32'(allowed), 1);
    end
    drive(sw1, 1'b1, 1'b0);
    check("t5_full", 32'(mem_ops), 8);
    check("t5_9th_rej", 32'(allowed), 0);
    drive(nop, 1'b0, 1'b0);
    check("t5_sat", 32'(mem_ops), 8);
    check("t5_viol", 32'(violation), 1);
    drive(sw1, 1'b0, 1'b1);
    check("t5_preclear_rej", 32'(allowed), 0);
    drive(sw1, 1'b1, 1'b0);
    check("t5_clr_mem", 32'(mem_ops), 0);
    check("t5_clr_viol", 32'(violation), 0);
    check("t5_sw_again", 32'(allowed), 1);
    drive(nop, 1'b0, 1'b0);
    check("t5_count1", 32'(mem_ops), 1);

    // 6: asynchronous reset mid-shadow
    drive(lw5, 1'b1, 1'b0);
    drive(sw5, 1'b0, 1'b0);
    check("t6_shadow", 32'(shadow), 1);
    check("t6_sw_rs2_hit", 32'(allowed), 0);
    check("t6_mem_ops", 32'(mem_ops), 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_shadow", 32'(shadow), 0);
    check("t6_async_mem", 32'(mem_ops), 0);
    rst = 1'b0;
    drive(add651, 1'b1, 1'b0);
    check("t6_add_ok", 32'(allowed), 1);
    drive(nop, 1'b0, 1'b0);
    check("t6_no_shadow", 32'(shadow), 0);
    check("t6_no_viol", 32'(violation), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_qed_inst_constraint_seq
`default_nettype wire
